// File: rtl/srff_chk_pkg.sv
// Shared types and the golden SR next-state rule
// used by the SR flip-flop response checker.
package srff_chk_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SYNC  = 2'd1,
        ST_CHECK = 2'd2
    } state_e;

    localparam int INV_UNDEF  = 0;
    localparam int INV_TOGGLE = 1;
    localparam int INV_HOLD   = 2;

    // s=r=1 under INV_UNDEF holds here; the checker never compares that result
    function automatic logic sr_next(
        input logic q,
        input logic s,
        input logic r,
        input int   mode
    );
        logic n;
        n = q;
        case ({s, r})
            2'b00:   n = q;
            2'b01:   n = 1'b0;
            2'b10:   n = 1'b1;
            2'b11:   n = (mode == INV_TOGGLE) ? ~q : q;
            default: n = q;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/srff_golden_model.sv
// Golden SR state: loads the DUT state on resync,
// otherwise advances by the SR next-state rule.
module srff_golden_model
    import srff_chk_pkg::*;
#(
    parameter int INVALID_MODE = INV_TOGGLE
) (
    input  logic clk,
    input  logic rst,
    input  logic load_i,
    input  logic step_i,
    input  logic q_i,
    input  logic s_i,
    input  logic r_i,
    output logic ref_q_o
);

    logic ref_q_q;
    logic ref_q_d;

    always_comb begin
        ref_q_d = ref_q_q;
        if (load_i) begin
            ref_q_d = q_i;
        end else if (step_i) begin
            ref_q_d = sr_next(ref_q_q, s_i, r_i, INVALID_MODE);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ref_q_q <= 1'b0;
        end else begin
            ref_q_q <= ref_q_d;
        end
    end

    assign ref_q_o = ref_q_q;

endmodule

// File: rtl/srff_response_checker.sv
// Monitors an SR flip-flop: tracks a golden state, compares q/qbar
// one cycle after s/r are sampled, and counts errors and invalid requests.
module srff_response_checker
    import srff_chk_pkg::*;
#(
    parameter int CNT_W        = 8,
    parameter int INVALID_MODE = INV_UNDEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             s,
    input  logic             r,
    input  logic             q,
    input  logic             qbar,
    output logic             ref_q,
    output logic             mismatch,
    output logic             invalid_seen,
    output logic             sticky_fail,
    output logic [CNT_W-1:0] chk_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] inv_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_e           state_q, state_d;
    logic             exp_valid_q, exp_valid_d;
    logic             load, step;
    logic             do_cmp, is_inv, miss;
    logic             mismatch_q, invalid_q, sticky_q;
    logic [CNT_W-1:0] chk_q, err_q, inv_q;

    always_comb begin
        state_d     = state_q;
        exp_valid_d = exp_valid_q;
        load        = 1'b0;
        step        = 1'b0;
        if (!en) begin
            state_d     = ST_IDLE;
            exp_valid_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_SYNC;
                end
                ST_SYNC: begin
                    load        = 1'b1;
                    exp_valid_d = 1'b0;
                    state_d     = ST_CHECK;
                end
                ST_CHECK: begin
                    step        = 1'b1;
                    exp_valid_d = 1'b1;
                    // undefined s=r=1 response: drop the expectation and resync
                    if (s && r && INVALID_MODE == INV_UNDEF) begin
                        exp_valid_d = 1'b0;
                        state_d     = ST_SYNC;
                    end
                end
                default: begin
                    state_d     = ST_IDLE;
                    exp_valid_d = 1'b0;
                end
            endcase
        end
    end

    srff_golden_model #(
        .INVALID_MODE(INVALID_MODE)
    ) u_golden (
        .clk    (clk),
        .rst    (rst),
        .load_i (load),
        .step_i (step),
        .q_i    (q),
        .s_i    (s),
        .r_i    (r),
        .ref_q_o(ref_q)
    );

    assign do_cmp = en && (state_q == ST_CHECK) && exp_valid_q;
    assign is_inv = en && (state_q == ST_CHECK) && s && r;
    assign miss   = do_cmp && ((q !== ref_q) || (qbar !== ~q));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            exp_valid_q <= 1'b0;
            mismatch_q  <= 1'b0;
            invalid_q   <= 1'b0;
            sticky_q    <= 1'b0;
            chk_q       <= '0;
            err_q       <= '0;
            inv_q       <= '0;
        end else begin
            state_q     <= state_d;
            exp_valid_q <= exp_valid_d;
            mismatch_q  <= miss;
            invalid_q   <= is_inv;
            if (miss) begin
                sticky_q <= 1'b1;
            end
            if (do_cmp && chk_q != CNT_MAX) begin
                chk_q <= chk_q + CNT_ONE;
            end
            if (miss && err_q != CNT_MAX) begin
                err_q <= err_q + CNT_ONE;
            end
            if (is_inv && inv_q != CNT_MAX) begin
                inv_q <= inv_q + CNT_ONE;
            end
        end
    end

    assign mismatch     = mismatch_q;
    assign invalid_seen = invalid_q;
    assign sticky_fail  = sticky_q;
    assign chk_cnt      = chk_q;
    assign err_cnt      = err_q;
    assign inv_cnt      = inv_q;

endmodule

// File: tb/tb_srff_response_checker.sv
// Bench: JK-style SR flop with output fault injection, watched by
// four checker instances (modes 1/0/2 at CNT_W=8, mode 1 at CNT_W=2).
module tb_srff_response_checker;

    logic clk = 1'b0;
    logic rst, en, s, r;
    logic flip_q, flip_qb;
    logic f_q = 1'b0;
    logic q, qbar;

    always #5 clk = ~clk;

    // the flop under observation: 11 toggles like a JK-based SR flop
    always @(posedge clk) begin
        case ({s, r})
            2'b10:   f_q <= 1'b1;
            2'b01:   f_q <= 1'b0;
            2'b11:   f_q <= ~f_q;
            default: f_q <= f_q;
        endcase
    end

    assign q    = f_q ^ flip_q;
    assign qbar = ~q ^ flip_qb;

    logic       o_ref [4];
    logic       o_mm  [4];
    logic       o_inv [4];
    logic       o_stk [4];
    logic [7:0] o_chk [4];
    logic [7:0] o_err [4];
    logic [7:0] o_ic  [4];
    logic [1:0] c3_chk, c3_err, c3_ic;

    srff_response_checker #(.CNT_W(8), .INVALID_MODE(1)) u_m1 (
        .clk(clk), .rst(rst), .en(en), .s(s), .r(r), .q(q), .qbar(qbar),
        .ref_q(o_ref[0]), .mismatch(o_mm[0]), .invalid_seen(o_inv[0]),
        .sticky_fail(o_stk[0]), .chk_cnt(o_chk[0]), .err_cnt(o_err[0]),
        .inv_cnt(o_ic[0]));

    srff_response_checker #(.CNT_W(8), .INVALID_MODE(0)) u_m0 (
        .clk(clk), .rst(rst), .en(en), .s(s), .r(r), .q(q), .qbar(qbar),
        .ref_q(o_ref[1]), .mismatch(o_mm[1]), .invalid_seen(o_inv[1]),
        .sticky_fail(o_stk[1]), .chk_cnt(o_chk[1]), .err_cnt(o_err[1]),
        .inv_cnt(o_ic[1]));

    srff_response_checker #(.CNT_W(8), .INVALID_MODE(2)) u_m2 (
        .clk(clk), .rst(rst), .en(en), .s(s), .r(r), .q(q), .qbar(qbar),
        .ref_q(o_ref[2]), .mismatch(o_mm[2]), .invalid_seen(o_inv[2]),
        .sticky_fail(o_stk[2]), .chk_cnt(o_chk[2]), .err_cnt(o_err[2]),
        .inv_cnt(o_ic[2]));

    srff_response_checker #(.CNT_W(2), .INVALID_MODE(1)) u_c2 (
        .clk(clk), .rst(rst), .en(en), .s(s), .r(r), .q(q), .qbar(qbar),
        .ref_q(o_ref[3]), .mismatch(o_mm[3]), .invalid_seen(o_inv[3]),
        .sticky_fail(o_stk[3]), .chk_cnt(c3_chk), .err_cnt(c3_err),
        .inv_cnt(c3_ic));

    assign o_chk[3] = {6'd0, c3_chk};
    assign o_err[3] = {6'd0, c3_err};
    assign o_ic[3]  = {6'd0, c3_ic};

    int mode_c [4] = '{1, 0, 2, 1};
    int max_c  [4] = '{255, 255, 255, 3};

    // reference: phase 0 = monitor off, 1 = adopt DUT state next edge,
    // 2 = tracking; armed = a prediction is pending for this edge
    int   m_ph    [4];
    bit   m_armed [4];
    logic m_ref   [4];
    logic m_mm    [4];
    logic m_inv   [4];
    logic m_stk   [4];
    int   m_chk   [4];
    int   m_err   [4];
    int   m_ic    [4];

    int total = 0;
    int bad   = 0;

    task automatic model_edge(input int c);
        bit cmp, ms, iv;
        if (rst) begin
            m_ph[c] = 0; m_armed[c] = 0; m_ref[c] = 0;
            m_mm[c] = 0; m_inv[c] = 0; m_stk[c] = 0;
            m_chk[c] = 0; m_err[c] = 0; m_ic[c] = 0;
        end else if (!en) begin
            m_ph[c] = 0; m_armed[c] = 0;
            m_mm[c] = 0; m_inv[c] = 0;
        end else begin
            cmp = (m_ph[c] == 2) && m_armed[c];
            ms  = cmp && ((q !== m_ref[c]) || (qbar !== ~q));
            iv  = (m_ph[c] == 2) && s && r;
            m_mm[c]  = ms;
            m_inv[c] = iv;
            if (ms) m_stk[c] = 1;
            if (cmp) m_chk[c] = (m_chk[c] + 1 > max_c[c]) ? max_c[c] : m_chk[c] + 1;
            if (ms)  m_err[c] = (m_err[c] + 1 > max_c[c]) ? max_c[c] : m_err[c] + 1;
            if (iv)  m_ic[c]  = (m_ic[c] + 1 > max_c[c]) ? max_c[c] : m_ic[c] + 1;
            if (m_ph[c] == 0) begin
                m_ph[c] = 1;
            end else if (m_ph[c] == 1) begin
                m_ref[c] = q; m_armed[c] = 0; m_ph[c] = 2;
            end else begin
                m_armed[c] = 1;
                if (s && r) begin
                    if (mode_c[c] == 1) m_ref[c] = ~m_ref[c];
                    if (mode_c[c] == 0) begin
                        m_armed[c] = 0; m_ph[c] = 1;
                    end
                end else if (s) begin
                    m_ref[c] = 1;
                end else if (r) begin
                    m_ref[c] = 0;
                end
            end
        end
    endtask

    task automatic cyc(input logic i_rst, input logic i_en, input logic i_s,
                       input logic i_r, input logic i_fq, input logic i_fqb);
        @(negedge clk);
        rst = i_rst; en = i_en; s = i_s; r = i_r;
        flip_q = i_fq; flip_qb = i_fqb;
        #1;
        for (int c = 0; c < 4; c++) model_edge(c);
        @(posedge clk);
        #1;
    endtask

    function automatic logic [27:0] obs_vec(input int c);
        return {o_ref[c], o_mm[c], o_inv[c], o_stk[c], o_chk[c], o_err[c], o_ic[c]};
    endfunction

    function automatic logic [27:0] exp_vec(input int c);
        return {m_ref[c], m_mm[c], m_inv[c], m_stk[c],
                8'(m_chk[c]), 8'(m_err[c]), 8'(m_ic[c])};
    endfunction

    task automatic test_reset();
        cyc(1, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0);
        for (int c = 0; c < 4; c++) begin
            total++;
            if (obs_vec(c) !== 28'd0) begin
                bad++;
                $display("FAIL reset cfg%0d got=%h want=0", c, obs_vec(c));
            end
        end
    endtask

    task automatic test_basic();
        logic [3:0] sr_seq [4] = '{4'b01, 4'b00, 4'b10, 4'b00};
        logic       ref_w  [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        logic [3:0] cur;
        for (int i = 0; i < 4; i++) cyc(0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            cur = sr_seq[i];
            cyc(0, 1, cur[1], cur[0], 0, 0);
            total++;
            if (o_ref[0] !== ref_w[i]) begin
                bad++;
                $display("FAIL basic_ref step%0d got=%b want=%b", i, o_ref[0], ref_w[i]);
            end
            for (int c = 0; c < 4; c++) begin
                total++;
                if (obs_vec(c) !== exp_vec(c)) begin
                    bad++;
                    $display("FAIL basic cfg%0d got=%h want=%h", c, obs_vec(c), exp_vec(c));
                end
            end
        end
        total++;
        if (o_stk[0] !== 1'b0 || o_err[0] !== 8'd0) begin
            bad++;
            $display("FAIL basic_clean sticky=%b err=%0d want 0/0", o_stk[0], o_err[0]);
        end
    endtask

    task automatic test_invalid();
        logic [7:0] chk_at;
        cyc(0, 1, 1, 1, 0, 0);
        chk_at = o_chk[1];
        total++;
        if (o_inv[0] !== 1'b1 || o_ic[0] !== 8'd1 || o_ref[0] !== 1'b0) begin
            bad++;
            $display("FAIL invalid_toggle inv=%b cnt=%0d ref=%b want 1/1/0",
                     o_inv[0], o_ic[0], o_ref[0]);
        end
        for (int c = 0; c < 4; c++) begin
            total++;
            if (obs_vec(c) !== exp_vec(c)) begin
                bad++;
                $display("FAIL invalid cfg%0d got=%h want=%h", c, obs_vec(c), exp_vec(c));
            end
        end
        cyc(0, 1, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0);
        total++;
        if (o_chk[1] !== chk_at || o_inv[0] !== 1'b0) begin
            bad++;
            $display("FAIL invalid_resync chk=%0d want=%0d pulse=%b",
                     o_chk[1], chk_at, o_inv[0]);
        end
        cyc(0, 1, 0, 0, 0, 0);
        for (int c = 0; c < 4; c++) begin
            total++;
            if (obs_vec(c) !== exp_vec(c)) begin
                bad++;
                $display("FAIL invalid_after cfg%0d got=%h want=%h", c, obs_vec(c), exp_vec(c));
            end
        end
    endtask

    task automatic test_fault();
        cyc(0, 1, 0, 0, 1, 0);
        total++;
        if (o_mm[0] !== 1'b1 || o_err[0] !== 8'd1 || o_stk[0] !== 1'b1) begin
            bad++;
            $display("FAIL fault_q mm=%b err=%0d sticky=%b want 1/1/1",
                     o_mm[0], o_err[0], o_stk[0]);
        end
        cyc(0, 1, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 1);
        total++;
        if (o_mm[0] !== 1'b1 || o_err[0] !== 8'd2) begin
            bad++;
            $display("FAIL fault_qbar mm=%b err=%0d want 1/2", o_mm[0], o_err[0]);
        end
        cyc(0, 1, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0);
        total++;
        if (o_mm[0] !== 1'b0 || o_stk[0] !== 1'b1) begin
            bad++;
            $display("FAIL fault_sticky mm=%b sticky=%b want 0/1", o_mm[0], o_stk[0]);
        end
        for (int c = 0; c < 4; c++) begin
            total++;
            if (obs_vec(c) !== exp_vec(c)) begin
                bad++;
                $display("FAIL fault cfg%0d got=%h want=%h", c, obs_vec(c), exp_vec(c));
            end
        end
    endtask

    task automatic test_en_drop();
        logic [7:0] chk_at;
        chk_at = o_chk[0];
        cyc(0, 0, 0, 1, 0, 0);
        for (int i = 0; i < 3; i++) begin
            total++;
            if (o_chk[0] !== chk_at) begin
                bad++;
                $display("FAIL en_hold step%0d chk=%0d want=%0d", i, o_chk[0], chk_at);
            end
            cyc(0, 1, 0, 0, 0, 0);
        end
        total++;
        if (o_chk[0] !== chk_at) begin
            bad++;
            $display("FAIL en_arm chk=%0d want=%0d", o_chk[0], chk_at);
        end
        cyc(0, 1, 0, 0, 0, 0);
        total++;
        if (o_chk[0] !== chk_at + 8'd1) begin
            bad++;
            $display("FAIL en_resume chk=%0d want=%0d", o_chk[0], chk_at + 8'd1);
        end
    endtask

    task automatic test_random();
        logic e, rs, rr, fq, fb;
        for (int i = 0; i < 400; i++) begin
            e  = ($urandom_range(0, 19) != 0);
            rs = $urandom_range(0, 1);
            rr = $urandom_range(0, 1);
            fq = ($urandom_range(0, 15) == 0);
            fb = ($urandom_range(0, 15) == 0);
            cyc(0, e, rs, rr, fq, fb);
            for (int c = 0; c < 4; c++) begin
                total++;
                if (obs_vec(c) !== exp_vec(c)) begin
                    bad++;
                    $display("FAIL random i%0d cfg%0d got=%h want=%h",
                             i, c, obs_vec(c), exp_vec(c));
                end
            end
        end
    endtask

    task automatic test_mid_reset();
        cyc(1, 1, 1, 0, 0, 0);
        for (int c = 0; c < 4; c++) begin
            total++;
            if (obs_vec(c) !== 28'd0) begin
                bad++;
                $display("FAIL mid_reset cfg%0d got=%h want=0", c, obs_vec(c));
            end
        end
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 4; i++) cyc(0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) cyc(0, 1, 0, 0, 1, 0);
        total++;
        if (o_err[3] !== 8'd3 || o_err[0] !== 8'd5) begin
            bad++;
            $display("FAIL saturate err_w2=%0d err_w8=%0d want 3/5", o_err[3], o_err[0]);
        end
        for (int c = 0; c < 4; c++) begin
            total++;
            if (obs_vec(c) !== exp_vec(c)) begin
                bad++;
                $display("FAIL saturate cfg%0d got=%h want=%h", c, obs_vec(c), exp_vec(c));
            end
        end
        cyc(0, 1, 0, 0, 0, 0);
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; s = 1'b0; r = 1'b0;
        flip_q = 1'b0; flip_qb = 1'b0;
        test_reset();
        test_basic();
        test_invalid();
        test_fault();
        test_en_drop();
        test_random();
        test_mid_reset();
        test_saturation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
